// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequencing control for a multicycle RV32I datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port, traps on illegal opcodes and memory timeouts, counts retires.
// Optional build macro: CTRL_JUMP_EN makes JAL/JALR legal instructions.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int STATE_W     = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               branch,
  output logic               branch_geq,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR
  } opClass_t;

  // Wait counter only has to reach MEM_TIMEOUT-1; a timeout of 0 disables it.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_t            state, nextState;
  opClass_t          opClass, decClass;
  logic              decLegal;
  logic              geqReg;
  logic              retire;
  logic              waitLimit;
  logic [WAIT_W-1:0] waitCnt;
  logic [CNT_W-1:0]  retiredCnt;
  logic              unusedFunct3;

  assign unusedFunct3 = &{1'b0, funct3[1:0]};

  // This cycle would be the last permitted wait before a timeout trap.
  assign waitLimit = (MEM_TIMEOUT != 0) && (waitCnt == WAIT_LAST);

  // Classify the opcode currently presented by the instruction register.
  always_comb begin
    decClass = CL_R;
    decLegal = 1'b1;
    case (opcode)
      7'b0110011: decClass = CL_R;
      7'b0010011: decClass = CL_I;
      7'b0000011: decClass = CL_LOAD;
      7'b0100011: decClass = CL_STORE;
      7'b1100011: decClass = CL_BRANCH;
`ifdef CTRL_JUMP_EN
      7'b1101111: decClass = CL_JAL;
      7'b1100111: decClass = CL_JALR;
`endif
      default:    decLegal = 1'b0;
    endcase
  end

  // Next-state and control outputs; everything forced low while in reset.
  always_comb begin
    nextState  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    branch     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nextState = DECODE;
        end else if (waitLimit) begin
          nextState = TRAP;
        end
      end
      DECODE: nextState = decLegal ? EXEC : TRAP;
      EXEC: begin
        alu_src_a = 1'b1;
        case (opClass)
          CL_R: begin
            alu_op    = 2'b10;
            nextState = WB;
          end
          CL_I: begin
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
            nextState = WB;
          end
          CL_LOAD, CL_STORE: begin
            alu_src_b = 2'b10;
            nextState = MEM;
          end
          CL_BRANCH: begin
            alu_op    = 2'b01;
            branch    = 1'b1;
            retire    = 1'b1;
            nextState = FETCH;
          end
`ifdef CTRL_JUMP_EN
          CL_JAL, CL_JALR: begin
            alu_src_a = (opClass == CL_JALR);
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            nextState = WB;
          end
`endif
          default: nextState = TRAP;
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opClass == CL_STORE);
        if (mem_ready) begin
          if (opClass == CL_STORE) begin
            retire    = 1'b1;
            nextState = FETCH;
          end else begin
            nextState = WB;
          end
        end else if (waitLimit) begin
          nextState = TRAP;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opClass == CL_LOAD);
        retire     = 1'b1;
        nextState  = FETCH;
      end
      TRAP:    illegal = 1'b1;
      default: nextState = TRAP;
    endcase
    if (!reset_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      branch     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      retire     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= FETCH;
    else          state <= nextState;
  end

  // Latch opcode class in DECODE; branch_geq only moves on branches.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      opClass <= CL_R;
      geqReg  <= 1'b0;
    end else if (state == DECODE) begin
      opClass <= decClass;
      if (decLegal && decClass == CL_BRANCH) geqReg <= funct3[2];
    end
  end

  // Memory wait counter: restarts on entry to FETCH/MEM, counts stalled cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      waitCnt <= '0;
    end else if (nextState != state && (nextState == FETCH || nextState == MEM)) begin
      waitCnt <= '0;
    end else if ((state == FETCH || state == MEM) && !mem_ready) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset_n)    retiredCnt <= '0;
    else if (retire) retiredCnt <= retiredCnt + 1'b1;
  end

  assign retired    = reset_n ? retiredCnt : '0;
  assign branch_geq = reset_n & geqReg;
  assign state_o    = reset_n ? STATE_W'(state) : '0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed vector table, hand sequences for
// the multi-cycle corner cases, and random instruction streams checked against
// a per-instruction trace model.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;
  localparam int TO = 8;
  localparam int CW = 8;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  localparam int K_ILL = -1, K_R = 0, K_I = 1, K_LD = 2, K_ST = 3;
  localparam int K_BR = 4, K_JAL = 5, K_JALR = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, iord, ir_write, pc_write, alu_src_a;
  logic [1:0]    alu_src_b, alu_op;
  logic          branch, branch_geq, reg_write, mem_to_reg, illegal;
  logic [CW-1:0] retired;
  logic [2:0]    state_o;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW), .STATE_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .branch(branch),
    .branch_geq(branch_geq), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .retired(retired), .state_o(state_o)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, iord, irw, pcw, srcA;
    logic [1:0] srcB, aluOp;
    logic       br, rw, m2r, ill;
  } ctl_t;

  typedef struct {
    logic       rstN;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       rdy;
    ctl_t       exp;
    int         ret;
    logic       geq;
  } vec_t;

  vec_t vecs[$];
  int   checkCnt = 0;
  int   passCnt  = 0;
  int   modelRet = 0;
  logic modelGeq = 1'b0;

  function automatic int kindOf(input logic [6:0] o);
    case (o)
      OP_R:    return K_R;
      OP_I:    return K_I;
      OP_LD:   return K_LD;
      OP_ST:   return K_ST;
      OP_BR:   return K_BR;
`ifdef CTRL_JUMP_EN
      OP_JAL:  return K_JAL;
      OP_JALR: return K_JALR;
`endif
      default: return K_ILL;
    endcase
  endfunction

  function automatic ctl_t expFetch(input logic rdy);
    ctl_t c;
    c = '0; c.st = 3'd0; c.req = 1'b1; c.srcB = 2'b01; c.irw = rdy; c.pcw = rdy;
    return c;
  endfunction

  function automatic ctl_t expDecode();
    ctl_t c;
    c = '0; c.st = 3'd1;
    return c;
  endfunction

  function automatic ctl_t expExec(input int k);
    ctl_t c;
    c = '0; c.st = 3'd2; c.srcA = 1'b1;
    case (k)
      K_R:       c.aluOp = 2'b10;
      K_I:       begin c.srcB = 2'b10; c.aluOp = 2'b11; end
      K_LD, K_ST: c.srcB = 2'b10;
      K_BR:      begin c.aluOp = 2'b01; c.br = 1'b1; end
      K_JAL:     begin c.srcA = 1'b0; c.srcB = 2'b10; c.pcw = 1'b1; end
      K_JALR:    begin c.srcB = 2'b10; c.pcw = 1'b1; end
      default:   ;
    endcase
    return c;
  endfunction

  function automatic ctl_t expMem(input logic store);
    ctl_t c;
    c = '0; c.st = 3'd3; c.req = 1'b1; c.iord = 1'b1; c.we = store;
    return c;
  endfunction

  function automatic ctl_t expWb(input logic load);
    ctl_t c;
    c = '0; c.st = 3'd4; c.rw = 1'b1; c.m2r = load;
    return c;
  endfunction

  function automatic ctl_t expTrap();
    ctl_t c;
    c = '0; c.st = 3'd5; c.ill = 1'b1;
    return c;
  endfunction

  function automatic logic [6:0] junkOp();
    return 7'($urandom);
  endfunction

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drive one cycle of inputs, compare outputs on the falling edge.
  task automatic applyCycle(input logic rstN, input logic [6:0] opc, input logic [2:0] f3,
                            input logic rdy, input ctl_t exp, input int expRet,
                            input logic expGeq, input string nm);
    ctl_t act;
    reset_n = rstN; opcode = opc; funct3 = f3; mem_ready = rdy;
    @(negedge clk);
    act = {state_o, mem_req, mem_we, iord, ir_write, pc_write, alu_src_a,
           alu_src_b, alu_op, branch, reg_write, mem_to_reg, illegal};
    check({nm, " ctl"}, 32'(act), 32'(exp));
    check({nm, " retired"}, 32'(retired), 32'(CW'(expRet)));
    check({nm, " branch_geq"}, 32'(branch_geq), 32'(expGeq));
    @(posedge clk); #1;
  endtask

  task automatic modelCycle(input ctl_t exp, input logic [6:0] opc, input logic [2:0] f3,
                            input logic rdy, input string nm);
    applyCycle(1'b1, opc, f3, rdy, exp, modelRet, modelGeq, nm);
  endtask

  task automatic doReset();
    modelRet = 0;
    modelGeq = 1'b0;
    applyCycle(1'b0, junkOp(), 3'($urandom), rnd(), '0, 0, 1'b0, "reset");
  endtask

  task automatic trapSeq(input int n);
    for (int i = 0; i < n; i++) modelCycle(expTrap(), junkOp(), 3'($urandom), rnd(), "trap");
    doReset();
  endtask

  // Expected trace of one instruction, given the stall lengths it will see.
  task automatic runInstr(input logic [6:0] opc, input logic [2:0] f3, input int fWait,
                          input int mWait, input int trapLen);
    int k;
    k = kindOf(opc);
    for (int i = 0; i < fWait; i++) begin
      modelCycle(expFetch(1'b0), junkOp(), 3'($urandom), 1'b0, "fetch wait");
      if (TO != 0 && i + 1 == TO) begin
        trapSeq(trapLen);
        return;
      end
    end
    modelCycle(expFetch(1'b1), junkOp(), 3'($urandom), 1'b1, "fetch");
    modelCycle(expDecode(), opc, f3, rnd(), "decode");
    if (k == K_ILL) begin
      trapSeq(trapLen);
      return;
    end
    if (k == K_BR) modelGeq = f3[2];
    modelCycle(expExec(k), junkOp(), 3'($urandom), rnd(), "exec");
    if (k == K_BR) begin
      modelRet++;
      return;
    end
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i < mWait; i++) begin
        modelCycle(expMem(k == K_ST), junkOp(), 3'($urandom), 1'b0, "mem wait");
        if (TO != 0 && i + 1 == TO) begin
          trapSeq(trapLen);
          return;
        end
      end
      modelCycle(expMem(k == K_ST), junkOp(), 3'($urandom), 1'b1, "mem");
      if (k == K_ST) begin
        modelRet++;
        return;
      end
    end
    modelCycle(expWb(k == K_LD), junkOp(), 3'($urandom), rnd(), "wb");
    modelRet++;
  endtask

  initial begin
    // Directed table: reset, R-type, two branches, a store.
    vecs.push_back('{1'b0, 7'd0,    3'd0,   1'b1, '0,              0, 1'b0});
    vecs.push_back('{1'b1, OP_R,    3'd0,   1'b1, expFetch(1'b1),  0, 1'b0});
    vecs.push_back('{1'b1, OP_R,    3'd0,   1'b0, expDecode(),     0, 1'b0});
    vecs.push_back('{1'b1, OP_BAD,  3'd7,   1'b1, expExec(K_R),    0, 1'b0});
    vecs.push_back('{1'b1, OP_BAD,  3'd0,   1'b1, expWb(1'b0),     0, 1'b0});
    vecs.push_back('{1'b1, OP_BAD,  3'd0,   1'b1, expFetch(1'b1),  1, 1'b0});
    vecs.push_back('{1'b1, OP_BR,   3'b101, 1'b0, expDecode(),     1, 1'b0});
    vecs.push_back('{1'b1, OP_R,    3'b000, 1'b1, expExec(K_BR),   1, 1'b1});
    vecs.push_back('{1'b1, OP_BAD,  3'd0,   1'b1, expFetch(1'b1),  2, 1'b1});
    vecs.push_back('{1'b1, OP_BR,   3'b000, 1'b1, expDecode(),     2, 1'b1});
    vecs.push_back('{1'b1, OP_BR,   3'b111, 1'b0, expExec(K_BR),   2, 1'b0});
    vecs.push_back('{1'b1, OP_BAD,  3'd0,   1'b1, expFetch(1'b1),  3, 1'b0});
    vecs.push_back('{1'b1, OP_ST,   3'b110, 1'b1, expDecode(),     3, 1'b0});
    vecs.push_back('{1'b1, OP_LD,   3'd0,   1'b1, expExec(K_ST),   3, 1'b0});
    vecs.push_back('{1'b1, OP_LD,   3'd0,   1'b1, expMem(1'b1),    3, 1'b0});
    vecs.push_back('{1'b1, OP_BAD,  3'd0,   1'b0, expFetch(1'b0),  4, 1'b0});

    @(posedge clk); #1;
    foreach (vecs[i])
      applyCycle(vecs[i].rstN, vecs[i].opc, vecs[i].f3, vecs[i].rdy, vecs[i].exp,
                 vecs[i].ret, vecs[i].geq, $sformatf("vec%0d", i));

    // Hand sequences for stalls, traps and the timeout boundary.
    doReset();
    runInstr(OP_LD, 3'b010, 0, 3, 1);
    runInstr(OP_I, 3'b000, 2, 0, 1);
    runInstr(OP_BAD, 3'b000, 0, 0, 20);
    runInstr(OP_R, 3'b000, TO, 0, 3);
    runInstr(OP_R, 3'b000, TO - 1, 0, 1);
    runInstr(OP_ST, 3'b010, 1, TO - 1, 1);
    runInstr(OP_LD, 3'b010, 0, TO, 2);
    runInstr(OP_JAL, 3'b000, 0, 0, 2);
    runInstr(OP_JALR, 3'b000, 0, 0, 2);

    // Random instruction stream.
    for (int n = 0; n < 400; n++) begin
      int sel, fw, mw;
      logic [6:0] opc;
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1:    opc = OP_R;
        2, 3:    opc = OP_I;
        4:       opc = OP_LD;
        5:       opc = OP_ST;
        6, 7:    opc = OP_BR;
        8:       opc = OP_JAL;
        9:       opc = OP_JALR;
        default: opc = junkOp();
      endcase
      fw = ($urandom_range(0, 19) == 0) ? TO - $urandom_range(0, 1) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? TO - $urandom_range(0, 1) : $urandom_range(0, 3);
      runInstr(opc, 3'($urandom), fw, mw, $urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
